lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter: MEM_BYTES, 128, data-memory size in bytes; range-check limit.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports:
- req_valid  input  1  pipeline request present.
- req_ready  output  1  request accepted this cycle.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  0=byte, 1=half, 2=word; 3 is reserved.
- req_unsigned  input  1  zero-extend loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
REQ-005 SHALL have ports:
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes result.
- resp_rdata  output  32  extended load data; 0 for stores.
- resp_err  output  1  misaligned, out-of-range or reserved size.
REQ-006 SHALL have ports:
- dm_addr  output  32  word-aligned address.
- dm_w_data  output  32  write word.
- dm_w  output  1  write strobe.
- dm_r  output  1  read strobe.
- dm_r_data  input  32  combinational read data.

Function
REQ-007 SHALL implement FSM states IDLE, RD, WR, RESP; req_ready=1 only in IDLE.
REQ-008 SHALL latch all req_* fields in IDLE when req_valid&&req_ready.
REQ-009 SHALL map byte lane k (k=addr[1:0]) to bits [8k+7:8k]; halfword at addr[1]=h uses bits [16h+15:16h].
REQ-010 SHALL route IDLE to RESP with resp_err=1 and no dm_r/dm_w when addr+size_bytes>MEM_BYTES or req_size=3.
REQ-011 Load SHALL follow IDLE->RD(dm_r=1, capture extracted data)->RESP; resp_valid is asserted 2 cycles after acceptance.
REQ-012 Word store SHALL follow IDLE->WR(dm_w=1, dm_w_data=wdata)->RESP.
REQ-013 Byte and half stores SHALL perform read-modify-write: IDLE->RD(dm_r=1, capture word)->WR(dm_w=1, merged word, untouched lanes preserved)->RESP.
REQ-014 dm_addr SHALL equal {addr[31:2],2'b00} in RD and WR; dm_r and dm_w SHALL be 0 outside RD and WR respectively, and SHALL never both be 1.
REQ-015 Loads SHALL sign-extend from bit 7 (byte) or bit 15 (half) unless req_unsigned=1, in which case they zero-extend.
REQ-016 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-017 SHALL ignore req_valid in any state other than IDLE.

Reset
REQ-018 rst_n=0 SHALL immediately force IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, dm_r=0, dm_w=0, dm_addr=0, dm_w_data=0.
REQ-019 Reset mid-transaction SHALL abort it, with no dm_w pulse after rst_n asserts and no response issued.

Configuration
REQ-020 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL go IDLE->RESP with resp_err=1 and no memory access.
REQ-021 Without LSU_MISALIGN_TRAP_EN, low address bits SHALL be silently cleared to natural alignment, and no misalignment error is raised.

Structure
REQ-022 Package lsu_pkg SHALL hold the size encodings SZ_B/SZ_H/SZ_W/SZ_RSV and the FSM state enum.
REQ-023 Lane extract/extend and store-merge logic SHALL be the combinational sub-module lsu_align, instantiated once.

Verification
REQ-024 Word store then word load: sw 0x11223344 @0x10, then lw @0x10 -> resp_rdata=0x11223344, err=0; load resp 2 cycles after acceptance.
REQ-025 Byte store RMW: word @0x20=0xAABBCCDD, sb 0x5A @0x21 -> dm_w_data=0xAABB5ADD; exactly one dm_r then one dm_w.
REQ-026 Load extension: word @0x30=0x000080F0, lb @0x30 -> 0xFFFFFFF0; lbu @0x30 -> 0x000000F0; lh @0x30 -> 0xFFFF80F0.
REQ-027 Errors: lw @0x80 -> resp_err=1, no strobes; with LSU_MISALIGN_TRAP_EN, lh @0x03 -> resp_err=1; without it, lh @0x03 reads the half at @0x02.
REQ-028 Backpressure and reset: hold resp_ready=0 for 5 cycles -> response held stable and req_ready=0; assert rst_n=0 during the WR cycle -> dm_w drops immediately and the FSM returns to IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit controller:
//   - access size encodings SZ_B / SZ_H / SZ_W / SZ_RSV
//   - FSM state enumeration (IDLE, RD, WR, RESP)
//   - helper functions for access byte count and natural alignment
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Number of bytes touched by an access of the given size (0 for reserved).
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            SZ_W:    n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Clear the low address bits down to the natural alignment of the size.
    function automatic logic [31:0] align_addr(input logic [31:0] addr,
                                               input logic [1:0]  size);
        logic [31:0] a;
        a = addr;
        case (size)
            SZ_H:    a[0]   = 1'b0;
            SZ_W:    a[1:0] = 2'b00;
            default: a      = addr;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
// Bundles the pipeline request/response handshake and the data-memory port of
// the load/store unit.
//   slave  modport : seen by lsu_ctrl
//   master modport : seen by the pipeline / memory environment
// Request : req_valid, req_ready, req_we, req_size, req_unsigned, req_addr,
//           req_wdata
// Response: resp_valid, resp_ready, resp_rdata, resp_err
// Memory  : dm_addr, dm_w_data, dm_w, dm_r, dm_r_data (combinational read)
// -----------------------------------------------------------------------------
interface lsu_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] dm_addr;
    logic [31:0] dm_w_data;
    logic        dm_w;
    logic        dm_r;
    logic [31:0] dm_r_data;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  resp_ready, dm_r_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output dm_addr, dm_w_data, dm_w, dm_r
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output resp_ready, dm_r_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  dm_addr, dm_w_data, dm_w, dm_r
    );

endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane steering for the load/store unit.
//   i_word      : word read from data memory
//   i_byte_off  : address bits [1:0] (already naturally aligned for the size)
//   i_size      : access size (lsu_pkg SZ_*)
//   i_unsigned  : zero-extend loads when 1, sign-extend when 0
//   i_wdata     : right-justified store data
//   o_load_data : selected lane, extended to 32 bits
//   o_merged    : i_word with the addressed lane(s) replaced by store data
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_byte_off,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte / halfword lane and extend it to a full word.
    always_comb begin
        w_byte      = i_word[{i_byte_off, 3'b000} +: 8];
        w_half      = i_byte_off[1] ? i_word[31:16] : i_word[15:0];
        o_load_data = i_word;
        case (i_size)
            SZ_B: begin
                if (i_unsigned) begin
                    o_load_data = {24'd0, w_byte};
                end else begin
                    o_load_data = {{24{w_byte[7]}}, w_byte};
                end
            end
            SZ_H: begin
                if (i_unsigned) begin
                    o_load_data = {16'd0, w_half};
                end else begin
                    o_load_data = {{16{w_half[15]}}, w_half};
                end
            end
            default: o_load_data = i_word;
        endcase
    end

    // Overwrite only the addressed lane(s); untouched lanes keep memory data.
    always_comb begin
        o_merged = i_word;
        case (i_size)
            SZ_B: o_merged[{i_byte_off, 3'b000} +: 8] = i_wdata[7:0];
            SZ_H: begin
                if (i_byte_off[1]) begin
                    o_merged[31:16] = i_wdata[15:0];
                end else begin
                    o_merged[15:0]  = i_wdata[15:0];
                end
            end
            default: o_merged = i_wdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit controller between a pipeline request/response handshake and
// a single-port data memory with combinational read data.
//   clk   : single clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : lsu_ctrl_if.slave (request, response and data-memory signals)
// Parameter MEM_BYTES: data-memory size in bytes, used for range checking.
//
// Flow: IDLE accepts a request. Errors go straight to RESP. Loads and
// sub-word stores read in RD; sub-word stores then write the merged word in
// WR; word stores go straight to WR. RESP holds until resp_ready.
//
// Build option LSU_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses return resp_err without touching memory. When undefined, the low
// address bits are cleared to natural alignment and no error is raised.
// All outputs are registered, decoded from the next state.
// -----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus
);

    localparam logic [32:0] LP_MEM_LIMIT = 33'(MEM_BYTES);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;

    // Latched request fields
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_byte_off;
    logic [31:0] r_wdata;

    // Registered outputs and their next values
    logic        r_req_ready,  w_req_ready_nxt;
    logic        r_resp_valid, w_resp_valid_nxt;
    logic [31:0] r_resp_rdata, w_resp_rdata_nxt;
    logic        r_resp_err,   w_resp_err_nxt;
    logic        r_dm_r,       w_dm_r_nxt;
    logic        r_dm_w,       w_dm_w_nxt;
    logic [31:0] r_dm_addr,    w_dm_addr_nxt;
    logic [31:0] r_dm_w_data,  w_dm_w_data_nxt;

    logic        w_accept;
    logic [31:0] w_eff_addr;
    logic [32:0] w_end_addr;
    logic        w_range_err;
    logic        w_misalign;
    logic        w_req_err;
    logic        w_needs_read;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_accept   = (r_state == IDLE) && bus.req_valid && r_req_ready;
    assign w_eff_addr = align_addr(bus.req_addr, bus.req_size);

    // 33-bit sum so that addresses near 2^32 cannot wrap into range.
    assign w_end_addr  = {1'b0, w_eff_addr} + {30'd0, size_bytes(bus.req_size)};
    assign w_range_err = (w_end_addr > LP_MEM_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_size == SZ_H) && bus.req_addr[0]) ||
                        ((bus.req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_req_err    = w_range_err || w_misalign || (bus.req_size == SZ_RSV);
    // Loads and sub-word stores need the current memory word first.
    assign w_needs_read = !bus.req_we || (bus.req_size != SZ_W);

    lsu_align u_align (
        .i_word      (bus.dm_r_data),
        .i_byte_off  (r_byte_off),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    // Next-state and next-output decode; outputs are zero unless set.
    always_comb begin
        w_state_nxt      = r_state;
        w_req_ready_nxt  = 1'b0;
        w_resp_valid_nxt = 1'b0;
        w_resp_rdata_nxt = 32'd0;
        w_resp_err_nxt   = 1'b0;
        w_dm_r_nxt       = 1'b0;
        w_dm_w_nxt       = 1'b0;
        w_dm_addr_nxt    = 32'd0;
        w_dm_w_data_nxt  = 32'd0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_state_nxt      = RESP;
                        w_resp_valid_nxt = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                    end else if (w_needs_read) begin
                        w_state_nxt   = RD;
                        w_dm_r_nxt    = 1'b1;
                        w_dm_addr_nxt = {w_eff_addr[31:2], 2'b00};
                    end else begin
                        w_state_nxt     = WR;
                        w_dm_w_nxt      = 1'b1;
                        w_dm_addr_nxt   = {w_eff_addr[31:2], 2'b00};
                        w_dm_w_data_nxt = bus.req_wdata;
                    end
                end else begin
                    w_req_ready_nxt = 1'b1;
                end
            end
            RD: begin
                if (r_we) begin
                    w_state_nxt     = WR;
                    w_dm_w_nxt      = 1'b1;
                    w_dm_addr_nxt   = r_dm_addr;
                    w_dm_w_data_nxt = w_merged;
                end else begin
                    w_state_nxt      = RESP;
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = w_load_data;
                end
            end
            WR: begin
                w_state_nxt      = RESP;
                w_resp_valid_nxt = 1'b1;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt     = IDLE;
                    w_req_ready_nxt = 1'b1;
                end else begin
                    w_resp_valid_nxt = 1'b1;
                    w_resp_rdata_nxt = r_resp_rdata;
                    w_resp_err_nxt   = r_resp_err;
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_req_ready_nxt = 1'b1;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers; reset drops strobes and the response immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_dm_r       <= 1'b0;
            r_dm_w       <= 1'b0;
            r_dm_addr    <= 32'd0;
            r_dm_w_data  <= 32'd0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_dm_r       <= w_dm_r_nxt;
            r_dm_w       <= w_dm_w_nxt;
            r_dm_addr    <= w_dm_addr_nxt;
            r_dm_w_data  <= w_dm_w_data_nxt;
        end
    end

    // Capture the request fields on acceptance; they stay valid until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_byte_off <= 2'b00;
            r_wdata    <= 32'd0;
        end else if (w_accept) begin
            r_we       <= bus.req_we;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_byte_off <= w_eff_addr[1:0];
            r_wdata    <= bus.req_wdata;
        end else begin
            r_we       <= r_we;
            r_size     <= r_size;
            r_unsigned <= r_unsigned;
            r_byte_off <= r_byte_off;
            r_wdata    <= r_wdata;
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.dm_r       = r_dm_r;
    assign bus.dm_w       = r_dm_w;
    assign bus.dm_addr    = r_dm_addr;
    assign bus.dm_w_data  = r_dm_w_data;

endmodule
